// File: rtl/snap_axi_pkg.sv
// Shared AXI definitions for the snap memcpy datapath.
// Holds the read-burst FSM state encoding, the fixed AXI4 encodings used for
// 64 B beats and the burst geometry constants.
package snap_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } burst_state_t;

  localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int BEAT_BYTES      = 64;
  localparam int MAX_BURST_BEATS = 64;

endpackage

// File: rtl/axi_rd_out_reg.sv
// Single-stage registered output for the read-burst data stream.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              R handshake: capture load_data/load_last this cycle
//   load_data/last    beat payload and final-beat marker
//   can_load          register is empty or draining this cycle
//   dout_valid/ready  output handshake
//   dout_data/last    registered beat
module axi_rd_out_reg
  import snap_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  can_load,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_last
);

  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic                  last_p0;

  // A new beat may enter in the same cycle the held one leaves, which keeps
  // one beat per cycle while dout_ready stays high.
  assign can_load = !vld_p0 || dout_ready;

  // Stage p0: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      last_p0 <= 1'b0;
    end else if (load) begin
      vld_p0  <= 1'b1;
      data_p0 <= load_data;
      last_p0 <= load_last;
    end else if (dout_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign dout_valid = vld_p0;
  assign dout_data  = data_p0;
  assign dout_last  = last_p0;

endmodule

// File: rtl/axi_burst_rd_master.sv
// AXI4 INCR read-burst master: one burst per burst_start request, data
// returned as a registered, back-pressured stream.
// Optional feature macro: AXI_RD_RESP_CHECK_EN (rresp checking into resp_err).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   burst_start/addr/len            request (len 0..64 beats, 64 B aligned)
//   burst_done, burst_busy          completion pulse, not-idle status
//   m_axi_ar*                       AXI4 read address channel
//   m_axi_r*                        AXI4 read data channel (rid ignored)
//   dout_valid/ready/data/last      output stream
//   proto_err, resp_err             sticky error flags, cleared on new burst
module axi_burst_rd_master
  import snap_axi_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  burst_start,
  input  logic [ADDR_WIDTH-1:0] burst_addr,
  input  logic [7:0]            burst_len,
  output logic                  burst_done,
  output logic                  burst_busy,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_last,
  output logic                  proto_err,
  output logic                  resp_err
);

  burst_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            arlen_q;
  logic [6:0]            cnt_q;
  logic                  proto_err_q;
  logic                  accept_start;
  logic                  cnt_done;
  logic                  final_beat;
  logic                  can_load;
  logic                  r_hs;

  assign accept_start = (state_q == ST_IDLE) && burst_start;
  assign cnt_done     = ({1'b0, cnt_q} == len_q);
  assign final_beat   = (({1'b0, cnt_q} + 8'd1) == len_q);

  // The cycle between the final beat and DONE still sits in DATA; cnt_done
  // keeps rready low there so a surplus beat is never swallowed.
  assign m_axi_rready = (state_q == ST_DATA) && !cnt_done && can_load;
  assign r_hs         = m_axi_rvalid && m_axi_rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (burst_start) state_d = (burst_len != 8'd0) ? ST_ADDR : ST_DONE;
      ST_ADDR: if (m_axi_arready) state_d = ST_DATA;
      ST_DATA: if (cnt_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      len_q       <= 8'd0;
      arlen_q     <= 8'd0;
      cnt_q       <= 7'd0;
      proto_err_q <= 1'b0;
    end else if (accept_start) begin
      addr_q      <= burst_addr;
      len_q       <= burst_len;
      // A zero-length request never reaches ADDR; keep arlen at 0 then.
      arlen_q     <= (burst_len != 8'd0) ? (burst_len - 8'd1) : 8'd0;
      cnt_q       <= 7'd0;
      proto_err_q <= 1'b0;
    end else if (r_hs) begin
      cnt_q <= cnt_q + 7'd1;
      // Covers both an early rlast and a missing rlast on the counted end.
      if (m_axi_rlast != final_beat) proto_err_q <= 1'b1;
    end
  end

`ifdef AXI_RD_RESP_CHECK_EN
  logic resp_err_q;
  logic unused_rid;
  assign unused_rid = ^m_axi_rid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      resp_err_q <= 1'b0;
    else if (accept_start)                           resp_err_q <= 1'b0;
    else if (r_hs && (m_axi_rresp != AXI_RESP_OKAY)) resp_err_q <= 1'b1;
  end

  assign resp_err = resp_err_q;
`else
  logic unused_rd_side;
  assign unused_rd_side = ^{m_axi_rid, m_axi_rresp};
  assign resp_err       = 1'b0;
`endif

  axi_rd_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (r_hs),
    .load_data  (m_axi_rdata),
    .load_last  (final_beat),
    .can_load   (can_load),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_last  (dout_last)
  );

  assign burst_done    = (state_q == ST_DONE);
  assign burst_busy    = (state_q != ST_IDLE);
  assign m_axi_arvalid = (state_q == ST_ADDR);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = AXI_SIZE_64B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arid    = '0;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_axi_burst_rd_master.sv
// Directed testbench for axi_burst_rd_master with a data scoreboard.
// Honours AXI_RD_RESP_CHECK_EN for the resp_err expectation.
module tb_axi_burst_rd_master;

  localparam int DW = 512;
  localparam int AW = 64;
  localparam int IW = 1;

`ifdef AXI_RD_RESP_CHECK_EN
  localparam bit RESP_EXP = 1'b1;
`else
  localparam bit RESP_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          burst_start;
  logic [AW-1:0] burst_addr;
  logic [7:0]    burst_len;
  logic          burst_done;
  logic          burst_busy;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic [IW-1:0] m_axi_arid;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic [IW-1:0] m_axi_rid;
  logic          dout_valid;
  logic          dout_ready;
  logic [DW-1:0] dout_data;
  logic          dout_last;
  logic          proto_err;
  logic          resp_err;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;

  axi_burst_rd_master #(
    .ID_WIDTH(IW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .burst_start(burst_start), .burst_addr(burst_addr), .burst_len(burst_len),
    .burst_done(burst_done), .burst_busy(burst_busy),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arid(m_axi_arid),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rid(m_axi_rid),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_last(dout_last), .proto_err(proto_err), .resp_err(resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int i);
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++)
      v[k*32 +: 32] = a[31:0] ^ (32'(i) << 8) ^ (32'(k) * 32'h0100_0193);
    return v;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, {burst_done, burst_busy, m_axi_arvalid, m_axi_rready,
                        dout_valid, dout_last, proto_err, resp_err}, '0);
    chk({tag, "_araddr"}, m_axi_araddr, '0);
    chk({tag, "_arlen"}, m_axi_arlen, '0);
    chk({tag, "_dout_data"}, dout_data, '0);
    chk({tag, "_const"}, {m_axi_arsize, m_axi_arburst, m_axi_arid}, {3'b110, 2'b01, 1'b0});
  endtask

  // Called and returns at 1 time unit after a rising edge.
  task automatic run_burst(input logic [AW-1:0] a, input int len, input int last_at,
                           input int err_at, input bit toggle,
                           input bit exp_proto, input bit exp_resp);
    int   t0, sent, outs, done_cnt, done_cyc, last_cyc, first_cyc, busy_after, ar_cnt;
    bit   ar_done;
    exp_t e;
    t0 = cyc;
    burst_addr  = a;
    burst_len   = 8'(len);
    burst_start = 1'b1;
    @(posedge clk); #1;
    burst_start = 1'b0;
    chk("start_clears_errs", {proto_err, resp_err}, '0);
    if (len == 0) begin
      chk("len0_done", burst_done, 1'b1);
      chk("len0_arvalid", m_axi_arvalid, 1'b0);
      @(posedge clk); #1;
      chk("len0_after", {burst_done, burst_busy, m_axi_arvalid}, '0);
      return;
    end
    chk("arvalid_t1", m_axi_arvalid, 1'b1);
    ar_done = 0; sent = 0; outs = 0; done_cnt = 0; ar_cnt = 0;
    done_cyc = -1; last_cyc = -1; first_cyc = -1; busy_after = -1;
    for (int guard = 0; guard < 1000; guard++) begin
      m_axi_arready = !ar_done;
      m_axi_rvalid  = ar_done && (sent < len);
      m_axi_rdata   = beat_data(a, sent);
      m_axi_rlast   = (sent == last_at);
      m_axi_rresp   = (sent == err_at) ? 2'b10 : 2'b00;
      dout_ready    = toggle ? cyc[0] : 1'b1;
      @(negedge clk);
      if (m_axi_arvalid && m_axi_arready) begin
        chk("araddr", m_axi_araddr, a);
        chk("arlen", m_axi_arlen, 8'(len - 1));
        ar_done = 1;
        ar_cnt++;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        e.d = beat_data(a, sent);
        e.l = (sent == len - 1);
        sb.push_back(e);
        if (sent == 0) first_cyc = cyc;
        if (sent == len - 1) last_cyc = cyc;
        sent++;
      end
      if (dout_valid && dout_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1'b1, 1'b0);
        else begin
          e = sb.pop_front();
          chk("dout_data", dout_data, e.d);
          chk("dout_last", dout_last, e.l);
        end
        outs++;
      end
      if (burst_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = int'(burst_busy);
      if (done_cyc >= 0 && cyc > done_cyc && outs == len) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    m_axi_rvalid  = 1'b0;
    m_axi_arready = 1'b0;
    dout_ready    = 1'b1;
    chk("beats_out", outs, len);
    chk("sb_empty", sb.size(), 0);
    chk("ar_handshakes", ar_cnt, 1);
    chk("first_beat_lat", first_cyc - t0, 2);
    chk("done_pulses", done_cnt, 1);
    chk("done_lat", done_cyc - last_cyc, 2);
    chk("busy_after_done", busy_after, 0);
    chk("proto_err", proto_err, exp_proto);
    chk("resp_err", resp_err, exp_resp);
  endtask

  initial begin
    rst_n = 1'b0; burst_start = 1'b0; burst_addr = '0; burst_len = 8'd0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0; m_axi_rid = '0; dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_burst(64'h1000, 1, 0, -1, 1'b0, 1'b0, 1'b0);
    run_burst(64'h2000, 64, 63, -1, 1'b1, 1'b0, 1'b0);
    run_burst(64'h3000, 0, -1, -1, 1'b0, 1'b0, 1'b0);
    run_burst(64'h4000, 4, 1, -1, 1'b0, 1'b1, 1'b0);
    run_burst(64'h5000, 4, 3, 2, 1'b0, 1'b0, RESP_EXP);

    // Reset in the middle of a DATA phase.
    burst_addr = 64'h6000; burst_len = 8'd8; burst_start = 1'b1;
    @(posedge clk); #1;
    burst_start = 1'b0; m_axi_arready = 1'b1;
    @(posedge clk); #1;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b0;
    m_axi_rdata = beat_data(64'h6000, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_data_busy", {burst_busy, m_axi_rready, dout_valid}, 3'b111);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_reset");
    m_axi_rvalid = 1'b0;
    @(posedge clk); #1;
    chk_reset_outs("mid_reset_held");
    rst_n = 1'b1;
    sb.delete();
    @(posedge clk); #1;

    run_burst(64'h7000, 8, 7, -1, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
